// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the CORDIC vectoring engine.
package cordic_pkg;

   localparam int DATA_W = 8;
   localparam int ITER   = 8;
   localparam int FRAC   = 2;
   localparam int ANG_W  = 10;
   localparam int IW     = DATA_W + 3 + FRAC;
   localparam int MAG_W  = DATA_W + 2;
   localparam int CNT_W  = $clog2(ITER);

   localparam logic [ANG_W-1:0] ANG_HALF = 10'd512;

   // atan(2^-i) in binary radians, full circle = 1024
   localparam logic [ANG_W-1:0] ATAN_LUT [0:7] = '{
      10'd128, 10'd76, 10'd40, 10'd20, 10'd10, 10'd5, 10'd3, 10'd1
   };

   // Gain compensation K ~ 2^-1 + 2^-3 - 2^-6 - 2^-9; negative entries subtract
   localparam int K_SHIFT [0:3] = '{1, 3, -6, -9};

   typedef enum logic [1:0] {
      IDLE,
      ITERATE,
      SCALE
   } state_t;

endpackage

// File: rtl/cordic_vector_unit_kscale.sv
// Combinational shift-add multiplier applying the inverse CORDIC gain (~0.6074).
module cordic_kscale
   import cordic_pkg::*;
(
   input  logic signed [IW-1:0] x_i,
   output logic signed [IW-1:0] y_o
);

   always_comb begin
      y_o = '0;
      for (int k = 0; k < 4; k++) begin
         if (K_SHIFT[k] > 0) begin
            y_o = y_o + (x_i >>> K_SHIFT[k]);
         end else begin
            y_o = y_o - (x_i >>> (-K_SHIFT[k]));
         end
      end
   end

endmodule

// File: rtl/cordic_vector_unit.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per clock, yields magnitude and angle.
module cordic_vector_unit
   import cordic_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic signed [DATA_W-1:0] y_in,
   input  logic                     start,
   input  logic                     K_mode,
   output logic                     busy,
   output logic                     done,
   output logic        [MAG_W-1:0]  magnitude,
   output logic signed [ANG_W-1:0]  angle
);

   state_t                state_q, state_d;
   logic    [CNT_W-1:0]   iter_q, iter_d;
   logic signed [IW-1:0]  x_q, x_d;
   logic signed [IW-1:0]  y_q, y_d;
   logic    [ANG_W-1:0]   z_q, z_d;
   logic                  kmode_q, kmode_d;
   logic                  zero_q, zero_d;
   logic    [MAG_W-1:0]   mag_q, mag_d;
   logic    [ANG_W-1:0]   ang_q, ang_d;
   logic                  done_q, done_d;

   logic signed [IW-1:0]  xExt, yExt, xShift, yShift, xScaled, magF;

   cordic_kscale u_kscale (
      .x_i (x_q),
      .y_o (xScaled)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         iter_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         kmode_q <= 1'b0;
         zero_q  <= 1'b0;
         mag_q   <= '0;
         ang_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         kmode_q <= kmode_d;
         zero_q  <= zero_d;
         mag_q   <= mag_d;
         ang_q   <= ang_d;
         done_q  <= done_d;
      end
   end

   // Left half-plane operands are rotated by 180 deg up front so the iterations converge.
   always_comb begin
      xExt    = IW'(x_in) <<< FRAC;
      yExt    = IW'(y_in) <<< FRAC;
      xShift  = x_q >>> iter_q;
      yShift  = y_q >>> iter_q;
      magF    = kmode_q ? xScaled : x_q;

      state_d = state_q;
      iter_d  = iter_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      kmode_d = kmode_q;
      zero_d  = zero_q;
      mag_d   = mag_q;
      ang_d   = ang_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               kmode_d = K_mode;
               zero_d  = (x_in == '0) && (y_in == '0);
               iter_d  = '0;
               if (x_in[DATA_W-1]) begin
                  x_d = -xExt;
                  y_d = -yExt;
                  z_d = ANG_HALF;
               end else begin
                  x_d = xExt;
                  y_d = yExt;
                  z_d = '0;
               end
               state_d = ITERATE;
            end
         end
         ITERATE: begin
            if (!y_q[IW-1]) begin
               x_d = x_q + yShift;
               y_d = y_q - xShift;
               z_d = z_q + ATAN_LUT[iter_q];
            end else begin
               x_d = x_q - yShift;
               y_d = y_q + xShift;
               z_d = z_q - ATAN_LUT[iter_q];
            end
            iter_d = iter_q + 1'b1;
            if (iter_q == CNT_W'(ITER - 1)) begin
               state_d = SCALE;
            end
         end
         SCALE: begin
            mag_d   = zero_q ? '0 : MAG_W'(unsigned'(magF) >> FRAC);
            ang_d   = zero_q ? '0 : z_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign magnitude = mag_q;
   assign angle     = ang_q;

endmodule

// File: tb/tb_cordic_vector_unit.sv
// Self-checking bench: directed corner cases plus randomized jobs against a floating-point model.
module tb_cordic_vector_unit;

   logic              clk;
   logic              reset;
   logic signed [7:0] x_in;
   logic signed [7:0] y_in;
   logic              start;
   logic              K_mode;
   logic              busy;
   logic              done;
   logic        [9:0] magnitude;
   logic signed [9:0] angle;

   int checks = 0;
   int errors = 0;

   cordic_vector_unit dut (
      .clk       (clk),
      .reset     (reset),
      .x_in      (x_in),
      .y_in      (y_in),
      .start     (start),
      .K_mode    (K_mode),
      .busy      (busy),
      .done      (done),
      .magnitude (magnitude),
      .angle     (angle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected,
                              input int tol, input bit wrap);
      int diff;
      diff = observed - expected;
      if (wrap) begin
         diff = ((diff % 1024) + 1024) % 1024;
         if (diff >= 512) diff = diff - 1024;
      end
      checks++;
      if (diff > tol || diff < -tol) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d tol=%0d", tag, observed, expected, tol);
      end
   endtask

   // Ideal vector math: true magnitude (optionally with raw CORDIC gain) and atan2 in brads
   function automatic void refModel(input int x, input int y, input bit k,
                                    output int mag, output int ang);
      real r, a;
      if (x == 0 && y == 0) begin
         mag = 0;
         ang = 0;
         return;
      end
      r = $sqrt(real'(x * x + y * y));
      if (!k) r = r * 1.64676;
      mag = $rtoi(r);
      a = $atan2(real'(y), real'(x)) * 512.0 / 3.14159265358979;
      ang = $rtoi(a + ((a >= 0.0) ? 0.5 : -0.5));
   endfunction

   task automatic applyStimulus(input int x, input int y, input bit k);
      x_in   = 8'(x);
      y_in   = 8'(y);
      K_mode = k;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Returns at the negedge where done is observed (or after the cycle budget)
   task automatic runJob(input int x, input int y, input bit k, input bit disturb,
                         output int latency, output int busyCnt);
      applyStimulus(x, y, k);
      busyCnt = busy ? 1 : 0;
      latency = 0;
      while (!done && latency < 40) begin
         @(negedge clk);
         latency++;
         if (busy) busyCnt++;
         if (disturb && (latency == 3 || latency == 5)) begin
            x_in   = 8'(-x + 7);
            y_in   = 8'(y / 2 + 11);
            K_mode = ~k;
            start  = 1'b1;
         end else begin
            start  = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic jobCheck(input string tag, input int x, input int y, input bit k,
                           input int expMag, input int expAng, input int magTol,
                           input int angTol, input bit disturb);
      int lat, bc;
      runJob(x, y, k, disturb, lat, bc);
      checkOutput({tag, ".latency"}, lat, 9, 0, 1'b0);
      checkOutput({tag, ".busy"}, bc, 9, 0, 1'b0);
      checkOutput({tag, ".mag"}, int'(magnitude), expMag, magTol, 1'b0);
      checkOutput({tag, ".ang"}, int'(angle), expAng, angTol, 1'b1);
   endtask

   initial begin
      int m, a, x, y, doneSeen;
      bit k;
      reset  = 1'b0;
      start  = 1'b0;
      x_in   = '0;
      y_in   = '0;
      K_mode = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset.busy", int'(busy), 0, 0, 1'b0);
      checkOutput("reset.done", int'(done), 0, 0, 1'b0);
      checkOutput("reset.mag", int'(magnitude), 0, 0, 1'b0);
      checkOutput("reset.ang", int'(angle), 0, 0, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      jobCheck("x100k1", 100, 0, 1'b1, 100, 0, 1, 2, 1'b0);
      @(negedge clk);
      checkOutput("donewidth", int'(done), 0, 0, 1'b0);
      checkOutput("maghold", int'(magnitude), 100, 1, 1'b0);
      jobCheck("x100k0", 100, 0, 1'b0, 164, 0, 1, 2, 1'b0);
      jobCheck("y100", 0, 100, 1'b1, 100, 256, 1, 2, 1'b0);
      jobCheck("ym100", 0, -100, 1'b1, 100, -256, 1, 2, 1'b0);
      jobCheck("xm100", -100, 0, 1'b1, 100, -512, 1, 2, 1'b0);
      jobCheck("m128", -128, -128, 1'b0, 298, -384, 1, 2, 1'b0);
      jobCheck("p127", 127, 127, 1'b1, 179, 128, 1, 2, 1'b0);
      jobCheck("zero", 0, 0, 1'b1, 0, 0, 0, 0, 1'b0);

      // Restarts during a job must be ignored; then a start in the done cycle
      refModel(50, -70, 1'b1, m, a);
      jobCheck("ignore", 50, -70, 1'b1, m, a, 2, 3, 1'b1);
      refModel(-90, 30, 1'b0, m, a);
      jobCheck("b2b", -90, 30, 1'b0, m, a, 2, 3, 1'b0);
      @(negedge clk);

      // Abort mid-job
      applyStimulus(90, 40, 1'b1);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("abort.busy", int'(busy), 0, 0, 1'b0);
      checkOutput("abort.done", int'(done), 0, 0, 1'b0);
      checkOutput("abort.mag", int'(magnitude), 0, 0, 1'b0);
      checkOutput("abort.ang", int'(angle), 0, 0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      doneSeen = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkOutput("abort.nodone", doneSeen, 0, 0, 1'b0);
      refModel(90, 40, 1'b1, m, a);
      jobCheck("postreset", 90, 40, 1'b1, m, a, 2, 3, 1'b0);

      for (int n = 0; n < 24; n++) begin
         do begin
            x = int'($urandom_range(255)) - 128;
            y = int'($urandom_range(255)) - 128;
         end while (((x < 0) ? -x : x) + ((y < 0) ? -y : y) < 40);
         k = 1'($urandom_range(1));
         refModel(x, y, k, m, a);
         jobCheck($sformatf("rnd%0d", n), x, y, k, m, a, 2, 3, 1'b0);
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
